// File: rtl/inst_fetch_if.sv
// inst_fetch_if: memory and interpreter handshake between the fetch unit and its peers
interface inst_fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] inst;
  logic        start;
  logic        done;
  logic        pc_load;
  logic [15:0] pc_target;
  modport master (
    output mem_req, mem_addr, inst, start,
    input  mem_ack, mem_rdata, done, pc_load, pc_target
  );
  modport slave (
    input  mem_req, mem_addr, inst, start,
    output mem_ack, mem_rdata, done, pc_load, pc_target
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch FSM with memory timeout, PC sequencing and retire counter
module inst_fetch #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          FETCH_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  inst_fetch_if.master bus,
  output logic [15:0] PC,
  output logic        busy,
  output logic        fetch_err,
  output logic [15:0] inst_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] EXEC  = 2'd3;
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);
  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_inst;
  logic [15:0] r_count;
  logic [7:0]  r_tmo;
  logic        r_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= 16'h0000;
      r_count <= 16'h0000;
      r_tmo   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (run && !r_err) r_state <= FETCH;
        FETCH: begin
          if (bus.mem_ack) begin
            r_inst  <= bus.mem_rdata;
            r_state <= ISSUE;
            r_tmo   <= 8'd0;
          end else if (r_tmo == TMO_LAST) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_tmo   <= 8'd0;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        ISSUE: r_state <= EXEC;
        default: if (bus.done) begin
          r_pc    <= bus.pc_load ? bus.pc_target : r_pc + 16'd1;
          r_count <= r_count + 16'd1;
          r_state <= run ? FETCH : IDLE;
        end
      endcase
    end
  end
  always_comb begin
    bus.mem_req  = r_state == FETCH;
    bus.mem_addr = r_pc;
    bus.inst     = r_inst;
    bus.start    = r_state == ISSUE;
    PC           = r_pc;
    busy         = r_state != IDLE;
    fetch_err    = r_err;
    inst_count   = r_count;
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of fetch, issue, retire, branch, wrap, timeout and reset behaviour
module tb_inst_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic ack_en = 1'b1;
  logic ack_force = 1'b0;
  logic done = 1'b0;
  logic pc_load = 1'b0;
  logic [15:0] pc_target = 16'h0000;
  logic [15:0] PC, inst_count;
  logic busy, fetch_err;
  int n_cmp = 0;
  int n_err = 0;
  int starts = 0;
  int wide = 0;
  logic prev_start = 1'b0;
  inst_fetch_if bus();
  assign bus.mem_ack   = (bus.mem_req & ack_en) | ack_force;
  assign bus.mem_rdata = 16'h4000 + bus.mem_addr;
  assign bus.done      = done;
  assign bus.pc_load   = pc_load;
  assign bus.pc_target = pc_target;
  inst_fetch #(.RESET_PC(16'h0000), .FETCH_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .run(run), .bus(bus),
    .PC(PC), .busy(busy), .fetch_err(fetch_err), .inst_count(inst_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.start) starts <= starts + 1;
    if (bus.start && prev_start) wide <= wide + 1;
    prev_start <= bus.start;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    int snap;
    int reqs;
    tick();
    tick();
    reset = 1'b0;
    check("rst_pc", PC, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_req", 16'(bus.mem_req), 16'h0);
    check("rst_inst", bus.inst, 16'h0000);
    check("rst_cnt", inst_count, 16'h0000);
    check("rst_err", 16'(fetch_err), 16'h0);
    tick();
    check("idle_noreq", 16'(bus.mem_req), 16'h0);
    run = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("fetch_req", 16'(bus.mem_req), 16'h1);
      check("fetch_addr", bus.mem_addr, 16'(i));
      tick();
      check("issue_start", 16'(bus.start), 16'h1);
      check("issue_inst", bus.inst, 16'h4000 + 16'(i));
      tick();
      check("exec_start", 16'(bus.start), 16'h0);
      check("exec_req", 16'(bus.mem_req), 16'h0);
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("seq_pc", PC, 16'(i + 1));
      check("seq_cnt", inst_count, 16'(i + 1));
    end
    check("start_pulses", 16'(starts), 16'd3);
    check("start_width", 16'(wide), 16'd0);
    tick();
    tick();
    pc_load = 1'b1;
    pc_target = 16'h0020;
    done = 1'b1;
    tick();
    check("branch_addr", bus.mem_addr, 16'h0020);
    check("branch_cnt", inst_count, 16'd4);
    pc_target = 16'hFFFF;
    done = 1'b0;
    tick();
    tick();
    done = 1'b1;
    tick();
    pc_load = 1'b0;
    done = 1'b0;
    check("jump_ffff", PC, 16'hFFFF);
    tick();
    check("inst_ffff", bus.inst, 16'h3FFF);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("pc_wrap", PC, 16'h0000);
    check("wrap_cnt", inst_count, 16'd6);
    tick();
    tick();
    run = 1'b0;
    tick();
    check("exec_hold_busy", 16'(busy), 16'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("stop_pc", PC, 16'h0001);
    check("stop_cnt", inst_count, 16'd7);
    check("stop_busy", 16'(busy), 16'h0);
    tick();
    check("stop_noreq", 16'(bus.mem_req), 16'h0);
    done = 1'b1;
    pc_load = 1'b1;
    pc_target = 16'h1234;
    ack_force = 1'b1;
    tick();
    tick();
    done = 1'b0;
    pc_load = 1'b0;
    ack_force = 1'b0;
    check("stray_pc", PC, 16'h0001);
    check("stray_cnt", inst_count, 16'd7);
    check("stray_inst", bus.inst, 16'h4000);
    check("stray_busy", 16'(busy), 16'h0);
    run = 1'b1;
    tick();
    tick();
    tick();
    done = 1'b1;
    reset = 1'b1;
    tick();
    done = 1'b0;
    reset = 1'b0;
    run = 1'b0;
    check("mid_rst_pc", PC, 16'h0000);
    check("mid_rst_cnt", inst_count, 16'd0);
    check("mid_rst_busy", 16'(busy), 16'h0);
    check("mid_rst_inst", bus.inst, 16'h0000);
    ack_en = 1'b0;
    run = 1'b1;
    snap = starts;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_req) reqs++;
    end
    check("tmo_req_cycles", 16'(reqs), 16'd8);
    check("tmo_err", 16'(fetch_err), 16'h1);
    check("tmo_busy", 16'(busy), 16'h0);
    check("tmo_pc", PC, 16'h0000);
    check("tmo_nostart", 16'(starts - snap), 16'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("err_clear", 16'(fetch_err), 16'h0);
    tick();
    check("refetch_req", 16'(bus.mem_req), 16'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 8, maximum cycles FETCH waits for mem_ack, counting the entry cycle; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  enables fetching; sampled in IDLE and when leaving EXECUTE.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  16  read address; equals PC whenever mem_req=1.
REQ-008 mem_ack  input  1  memory has mem_rdata valid this cycle.
REQ-009 mem_rdata  input  16  instruction word from memory.
REQ-010 inst  output  16  registered instruction handed to the interpreter.
REQ-011 start  output  1  one-cycle pulse telling the interpreter inst is valid.
REQ-012 done  input  1  interpreter has finished the current instruction.
REQ-013 pc_load  input  1  qualified by done; replace sequential PC with pc_target.
REQ-014 pc_target  input  16  branch/jump destination.
REQ-015 PC  output  16  current program counter.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 fetch_err  output  1  sticky; set on memory timeout.
REQ-018 inst_count  output  16  instructions retired; wraps FFFF->0000.

Function
REQ-019 FSM states IDLE, FETCH, ISSUE, EXECUTE; exactly one active per cycle.
REQ-020 IDLE: mem_req=0, start=0; if run=1 and fetch_err=0 go FETCH next cycle, else stay.
REQ-021 FETCH: mem_req=1, mem_addr=PC; timeout counter starts at 0 on entry, +1 per cycle without ack.
REQ-022 FETCH with mem_ack=1: inst<=mem_rdata, go ISSUE; ack honoured on the entry cycle itself (zero-wait memory).
REQ-023 FETCH, no ack, counter reaches FETCH_TIMEOUT-1: set fetch_err, drop mem_req, go IDLE; PC unchanged.
REQ-024 fetch_err, once set, blocks IDLE->FETCH until reset.
REQ-025 ISSUE: start=1 for exactly this one cycle; inst stable; go EXECUTE.
REQ-026 EXECUTE: start=0, mem_req=0, inst held stable; wait indefinitely for done.
REQ-027 EXECUTE with done=1, pc_load=0: PC<=PC+1 (16-bit wrap, FFFF->0000).
REQ-028 EXECUTE with done=1, pc_load=1: PC<=pc_target; no increment.
REQ-029 EXECUTE with done=1: inst_count<=inst_count+1; then FETCH if run=1, else IDLE.
REQ-030 done or pc_load outside EXECUTE: ignored, no state/PC/count change.
REQ-031 mem_ack outside FETCH: ignored; inst unchanged.
REQ-032 run deasserted during FETCH/ISSUE/EXECUTE: current instruction completes; stop at next EXECUTE exit.
REQ-033 Latency: run rising in IDLE to start pulse = 2 cycles with zero-wait memory (IDLE->FETCH->ISSUE); done to next start = 2 cycles.

Reset
REQ-034 reset=1 at a clock edge: state<=IDLE, PC<=RESET_PC, inst<=0, start=0, mem_req=0, busy=0, fetch_err=0, inst_count=0, timeout counter=0.
REQ-035 reset takes priority over all inputs in any state, including mid-FETCH and mid-EXECUTE; an in-flight instruction is abandoned, not counted.
REQ-036 After reset release, no mem_req before the cycle following run=1 being sampled in IDLE.

Verification
REQ-037 Reset, run=1, zero-wait memory returns 16'h4000 at PC 0 -> mem_addr=0, inst=4000, one-cycle start 2 cycles after run, done -> PC=1, inst_count=1.
REQ-038 Three sequential instructions at PC 0..2, done each 3 cycles after start -> PC=3, inst_count=3, start pulses exactly 3, each one cycle wide.
REQ-039 done with pc_load=1, pc_target=16'h0020 -> next mem_addr=0020; PC=FFFF with pc_load=0 -> PC wraps to 0000.
REQ-040 mem_ack withheld, FETCH_TIMEOUT=8 -> mem_req high 8 cycles, fetch_err=1, state IDLE, PC unchanged, no start; run held high -> no further mem_req until reset.
REQ-041 reset asserted during EXECUTE with done arriving the same cycle -> PC=RESET_PC, inst_count=0, busy=0; stray done/mem_ack in IDLE -> no change.
REQ-042 run dropped during EXECUTE -> done retires instruction (PC+1, count+1), FSM enters IDLE, mem_req stays 0.
